// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared types and width helpers for the multi-channel debouncer.
//   t_db_state  : per-channel debounce FSM state
//   tick_cnt_w  : prescaler counter width for a given period
//   stab_cnt_w  : stability counter width for a given tick count
// ---------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic [1:0] {
      e_zero  = 2'd0,
      e_wait1 = 2'd1,
      e_one   = 2'd2,
      e_wait0 = 2'd3
   } t_db_state;

   // Prescaler counts 0..period-1.
   function automatic int tick_cnt_w(input int period);
      return $clog2(period);
   endfunction

   // Stability counter must be able to hold 0..stable_ticks.
   function automatic int stab_cnt_w(input int stable_ticks);
      return $clog2(stable_ticks + 1);
   endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// ---------------------------------------------------------------------------
// debounce_tick_gen
// Free-running prescaler. o_tick is high for the single cycle in which the
// counter sits at TICK_PERIOD_10NS-1, i.e. once every TICK_PERIOD_10NS cycles.
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset (counter back to 0)
//   o_tick  one-cycle tick
// ---------------------------------------------------------------------------
module debounce_tick_gen
   import debounce_pkg::*;
#(
   parameter int TICK_PERIOD_10NS = 2_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam int                CNT_W    = tick_cnt_w(TICK_PERIOD_10NS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_PERIOD_10NS - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   // Decoded from the count register; 0 while in reset because count is 0.
   assign o_tick = (count == CNT_LAST);

endmodule

// File: rtl/debouncer_multi.sv
// ---------------------------------------------------------------------------
// debouncer_multi
// N-channel switch/button debouncer. Each raw input is synchronised and then
// filtered by its own 4-state FSM; a new level is accepted only after the
// synchronised input has held it across STABLE_TICKS prescaler ticks.
// Ports:
//   i_clk           system clock
//   i_rst           synchronous active-high reset
//   i_sw            raw asynchronous switch inputs, one bit per channel
//   o_sw_debounced  debounced level per channel
//   o_rising        one-cycle pulse on an accepted 0->1 change
//   o_falling       one-cycle pulse on an accepted 1->0 change
//   o_tick          shared prescaler tick
// ---------------------------------------------------------------------------
module debouncer_multi
   import debounce_pkg::*;
#(
   parameter int N_CH             = 4,
   parameter int TICK_PERIOD_10NS = 2_000_000,
   parameter int STABLE_TICKS     = 2,
   parameter int SYNC_STAGES      = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [N_CH-1:0] i_sw,
   output logic [N_CH-1:0] o_sw_debounced,
   output logic [N_CH-1:0] o_rising,
   output logic [N_CH-1:0] o_falling,
   output logic            o_tick
);

   localparam int                CNT_W    = stab_cnt_w(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic tick;

   debounce_tick_gen #(
      .TICK_PERIOD_10NS (TICK_PERIOD_10NS)
   ) u_tick_gen (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .o_tick (tick)
   );

   assign o_tick = tick;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_p0;
      logic                   s;
      t_db_state              state;
      logic [CNT_W-1:0]       cnt;
      logic                   rise_p1;
      logic                   fall_p1;

      // --- synchroniser stage: bit 0 takes the raw pin ---
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            sync_p0 <= '0;
         end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], i_sw[g]};
         end
      end

      assign s = sync_p0[SYNC_STAGES-1];

      // --- debounce FSM stage ---
      // The level check is tested before the tick so that a bounce
      // coinciding with a tick still aborts the wait.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            state   <= e_zero;
            cnt     <= '0;
            rise_p1 <= 1'b0;
            fall_p1 <= 1'b0;
         end else begin
            rise_p1 <= 1'b0;
            fall_p1 <= 1'b0;
            case (state)
               e_zero: begin
                  if (s) begin
                     state <= e_wait1;
                     cnt   <= '0;
                  end
               end
               e_wait1: begin
                  if (!s) begin
                     state <= e_zero;
                  end else if (tick) begin
                     if (cnt == CNT_LAST) begin
                        state   <= e_one;
                        rise_p1 <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               e_one: begin
                  if (!s) begin
                     state <= e_wait0;
                     cnt   <= '0;
                  end
               end
               e_wait0: begin
                  if (s) begin
                     state <= e_one;
                  end else if (tick) begin
                     if (cnt == CNT_LAST) begin
                        state   <= e_zero;
                        fall_p1 <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               default: state <= e_zero;
            endcase
         end
      end

      // Level stays high while a release is still being qualified.
      assign o_sw_debounced[g] = (state == e_one) || (state == e_wait0);
      assign o_rising[g]       = rise_p1;
      assign o_falling[g]      = fall_p1;
   end

endmodule

// File: tb/tb_debouncer_multi.sv
// ---------------------------------------------------------------------------
// tb_debouncer_multi
// Self-checking bench for debouncer_multi with N_CH=4, TICK_PERIOD_10NS=4,
// STABLE_TICKS=3, SYNC_STAGES=2. A behavioural model (input delay line,
// cycles-since-reset tick, per-channel "candidate level held for N ticks")
// is compared against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_debouncer_multi;

   localparam int NCH = 4;
   localparam int P   = 4;
   localparam int ST  = 3;
   localparam int SS  = 2;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b1;
   logic [NCH-1:0] i_sw  = '0;
   logic [NCH-1:0] o_sw_debounced;
   logic [NCH-1:0] o_rising;
   logic [NCH-1:0] o_falling;
   logic           o_tick;

   debouncer_multi #(
      .N_CH             (NCH),
      .TICK_PERIOD_10NS (P),
      .STABLE_TICKS     (ST),
      .SYNC_STAGES      (SS)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_sw           (i_sw),
      .o_sw_debounced (o_sw_debounced),
      .o_rising       (o_rising),
      .o_falling      (o_falling),
      .o_tick         (o_tick)
   );

   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endfunction

   // ---------------- behavioural reference model ----------------
   logic [NCH-1:0] m_q[$];     // past i_sw samples, newest first
   int             m_cyc;      // cycles since reset release
   logic [NCH-1:0] m_lvl;      // accepted level
   logic [NCH-1:0] m_wait;     // a different level is being qualified
   int             m_n[NCH];   // ticks seen while qualifying
   logic [NCH-1:0] m_rise;
   logic [NCH-1:0] m_fall;

   function automatic void model_edge(input logic r, input logic [NCH-1:0] sw);
      logic           tick_pre;
      logic [NCH-1:0] s_pre;
      if (r) begin
         m_q = {};
         for (int i = 0; i < SS; i++) m_q.push_back('0);
         m_cyc  = 0;
         m_lvl  = '0;
         m_wait = '0;
         m_rise = '0;
         m_fall = '0;
         for (int c = 0; c < NCH; c++) m_n[c] = 0;
      end else begin
         tick_pre = ((m_cyc % P) == P - 1);
         s_pre    = m_q[SS-1];
         m_rise   = '0;
         m_fall   = '0;
         for (int c = 0; c < NCH; c++) begin
            if (!m_wait[c]) begin
               if (s_pre[c] != m_lvl[c]) begin
                  m_wait[c] = 1'b1;
                  m_n[c]    = 0;
               end
            end else if (s_pre[c] == m_lvl[c]) begin
               m_wait[c] = 1'b0;
            end else if (tick_pre) begin
               m_n[c]++;
               if (m_n[c] == ST) begin
                  m_lvl[c]  = s_pre[c];
                  m_wait[c] = 1'b0;
                  if (s_pre[c]) m_rise[c] = 1'b1;
                  else          m_fall[c] = 1'b1;
               end
            end
         end
         m_q.push_front(sw);
         void'(m_q.pop_back());
         m_cyc++;
      end
   endfunction

   // One clock: drive inputs, let the edge happen, sample at the falling edge.
   task automatic cyc(input logic r, input logic [NCH-1:0] sw);
      i_rst = r;
      i_sw  = sw;
      @(posedge i_clk);
      model_edge(r, sw);
      @(negedge i_clk);
      chk("model_level",   32'(o_sw_debounced), 32'(m_lvl));
      chk("model_rising",  32'(o_rising),       32'(m_rise));
      chk("model_falling", 32'(o_falling),      32'(m_fall));
      chk("model_tick",    32'(o_tick),         32'((m_cyc % P) == P - 1));
      chk("rise_fall_excl", 32'(o_rising & o_falling), 32'(0));
   endtask

   task automatic hold(input int n, input logic [NCH-1:0] sw);
      for (int i = 0; i < n; i++) cyc(1'b0, sw);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic           rst;
      logic [NCH-1:0] sw;
      logic [NCH-1:0] deb;
      logic [NCH-1:0] rise;
      logic [NCH-1:0] fall;
      logic           tick;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int             lat;
      int             cnt;
      logic           found;
      logic           any;
      logic [NCH-1:0] sw;

      // Reset 3 cycles with all switches high, then release and keep them high.
      // Ticks land after edges 3,7,11; the third tick consumed while waiting
      // (edge 12) accepts the level.
      tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[2]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[4]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[5]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
      tbl[6]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[7]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[8]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[9]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
      tbl[10] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[11] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[12] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[13] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
      tbl[14] = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b0};
      tbl[15] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0};

      m_q = {};
      for (int i = 0; i < SS; i++) m_q.push_back('0);

      @(negedge i_clk);
      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].rst, tbl[i].sw);
         chk($sformatf("tbl%0d_level", i),   32'(o_sw_debounced), 32'(tbl[i].deb));
         chk($sformatf("tbl%0d_rising", i),  32'(o_rising),       32'(tbl[i].rise));
         chk($sformatf("tbl%0d_falling", i), 32'(o_falling),      32'(tbl[i].fall));
         chk($sformatf("tbl%0d_tick", i),    32'(o_tick),         32'(tbl[i].tick));
      end

      // Clean press on ch0 from an all-zero state.
      cyc(1'b1, 4'h0);
      hold(10, 4'h0);
      lat = 0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cyc(1'b0, 4'h1);
         lat++;
         if (o_sw_debounced[0]) found = 1'b1;
      end
      chk("press_accepted", 32'(found), 32'(1));
      chk("press_latency_window",
          32'((lat - SS >= (ST - 1) * P + 1) && (lat - SS <= ST * P + 1)), 32'(1));
      chk("press_rise_aligned", 32'(o_rising), 32'(4'h1));
      chk("press_others_low", 32'(o_sw_debounced[3:1]), 32'(0));
      cyc(1'b0, 4'h1);
      chk("press_rise_one_cycle", 32'(o_rising[0]), 32'(0));

      // Bounce on ch1: toggle every 3 cycles, then settle low.
      any = 1'b0;
      for (int i = 0; i < 40; i++) begin
         sw = 4'h1;
         sw[1] = ((i / 3) % 2) == 1;
         cyc(1'b0, sw);
         any |= o_sw_debounced[1] | o_rising[1] | o_falling[1];
      end
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 4'h1);
         any |= o_sw_debounced[1] | o_rising[1] | o_falling[1];
      end
      chk("bounce_ch1_quiet", 32'(any), 32'(0));

      // Release with glitch on ch2.
      hold(20, 4'h5);
      chk("ch2_high", 32'(o_sw_debounced[2]), 32'(1));
      any = 1'b0;
      for (int i = 0; i < 25; i++) begin
         cyc(1'b0, (i < 5) ? 4'h1 : 4'h5);
         any |= o_falling[2];
      end
      chk("glitch_no_fall", 32'(any), 32'(0));
      chk("glitch_level_held", 32'(o_sw_debounced[2]), 32'(1));
      cnt = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(1'b0, 4'h1);
         if (o_falling[2]) cnt++;
      end
      chk("release_single_fall", 32'(cnt), 32'(1));
      chk("release_level_low", 32'(o_sw_debounced[2]), 32'(0));

      // Simultaneous press on all channels.
      hold(25, 4'h0);
      found = 1'b0;
      for (int i = 0; i < 25 && !found; i++) begin
         cyc(1'b0, 4'hF);
         if (o_rising != '0) begin
            found = 1'b1;
            chk("simul_all_rise", 32'(o_rising), 32'(4'hF));
         end
      end
      chk("simul_seen", 32'(found), 32'(1));

      // Reset while ch3 is qualifying a press.
      hold(25, 4'h0);
      hold(6, 4'h8);
      chk("midwait_not_yet", 32'(o_sw_debounced[3]), 32'(0));
      cyc(1'b1, 4'h8);
      chk("midwait_in_reset", 32'({o_sw_debounced, o_rising, o_falling, o_tick}), 32'(0));
      cyc(1'b0, 4'h8);
      chk("midwait_after_reset", 32'({o_sw_debounced, o_rising, o_falling}), 32'(0));
      lat = 1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cyc(1'b0, 4'h8);
         lat++;
         if (o_sw_debounced[3]) found = 1'b1;
      end
      chk("midwait_accepted", 32'(found), 32'(1));
      chk("midwait_full_interval",
          32'((lat >= SS + (ST - 1) * P + 1) && (lat <= SS + ST * P + 1)), 32'(1));

      // Randomised traffic with occasional resets.
      sw = '0;
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(15) == 0) sw[c] = ~sw[c];
         cyc($urandom_range(199) == 0, sw);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
